vga_scan: RTL and testbench
===========================

Name: vga_scan

Overview:
- Scan-side counterpart to the per-pixel layer generators (ground, dinosaur, obstacles).
- Produces 640x480@60 Hz VGA timing from a 25 MHz pixel clock.
- Drives row_addr/col_addr out to the layer generators and takes back their registered pixel colour.
- Aligns that colour with delayed sync, and generates the frame-refresh strobe `fresh` that layers use for per-frame motion updates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- PX_LAT, 1, clocks from address to valid px_in (1..4)

Ports:
- clk  input  1  pixel clock, 25 MHz (clkdiv[1] of a 100 MHz board clock)
- rst_n  input  1  asynchronous active-low reset
- px_in  input  12  composited colour {r,g,b} for the address presented PX_LAT clocks earlier
- col_addr  output  10  current column, 0..639
- row_addr  output  9  current row, 0..479
- fresh  output  1  high during vertical blanking
- hs  output  1  horizontal sync, active low
- vs  output  1  vertical sync, active low
- de  output  1  aligned display-enable
- r  output  4  red
- g  output  4  green
- b  output  4  blue

Behaviour:
- Reset is asynchronous on rst_n low and sets:
  - h_cnt=0, v_cnt=0;
  - col_addr=0, row_addr=0, fresh=0;
  - hs=1, vs=1, de=0, r=g=b=0;
  - all delay-pipe stages to their idle values (sync=1, de=0).
- Asserting reset mid-frame restarts at pixel (0,0) on the first clock after release.
- h_cnt counts 0..H_TOTAL-1, where H_TOTAL = 800 (sum of the H parameters).
  - At wrap, h_cnt goes to 0 and v_cnt increments.
  - v_cnt wraps 0..V_TOTAL-1, where V_TOTAL = 525.
- Active region: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- col_addr = h_cnt when h_cnt<H_ACTIVE, else 0.
- row_addr = v_cnt[8:0] when v_cnt<V_ACTIVE, else 0.
- Addresses are driven straight from the counter registers, with no extra latency.
- Raw sync:
  - hs_raw = 0 for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw = 0 for 490 <= v_cnt < 492.
- Delay pipe:
  - hs_raw, vs_raw and de_raw pass through a shift register of depth PX_LAT.
  - Each output register then samples the last stage.
  - Total output delay is PX_LAT+1 clocks relative to the counters.
- Colour:
  - r,g,b register px_in when the delayed de stage is 1; otherwise they register 0.
  - Pixel (x,y) therefore appears on r/g/b exactly PX_LAT+1 clocks after h_cnt=x, v_cnt=y.
- fresh:
  - Registered; 1 while v_cnt>=V_ACTIVE, 0 otherwise.
  - Rises on the clock after v_cnt becomes 480 (with h_cnt=0).
  - Falls on the clock after v_cnt wraps to 0.
  - Exactly one rise and one fall per frame; never glitches.
- All counter compares use unsigned 10-bit arithmetic. No counter ever exceeds H_TOTAL-1 or V_TOTAL-1.

Optional Feature:
- Macro: VGA_BORDER_EN.
- When defined: for aligned pixels on column 0, column 639, row 0 or row 479, r/g/b = 4'hF each, overriding px_in. Interior pixels pass px_in unchanged. Border position tracks the delayed pipe, so it remains aligned with de.
- When undefined: px_in is always passed through, and no border logic is synthesized.
- Timing, ports and all other behaviour are identical in both builds.

Test Plan:
- Reset release, px_in=12'hABC constant:
  - col_addr counts 0..639, then holds 0 for h_cnt 640..799;
  - first de=1 occurs 2 clocks after release with r=A, g=B, b=C;
  - de is high for exactly 640 clocks per active line.
- Line timing:
  - hs falls 658 clocks after release and stays low 96 clocks;
  - line period is 800 clocks;
  - vs falls at clock 490*800+2 and stays low 1600 clocks;
  - frame period is 420000 clocks.
- fresh:
  - rises at clock 384001 and falls at clock 420001 after release;
  - exactly one rising edge per frame over 3 frames;
  - row_addr=0 throughout blanking.
- Address/colour alignment with PX_LAT=1, model returning px_in={col_addr[3:0],row_addr[3:0],4'h5} registered:
  - r/g/b equal the expected value for every active pixel of a full frame.
- Assert rst_n low at h_cnt=300, v_cnt=200 for 3 clocks:
  - outputs go to reset values immediately (asynchronously);
  - after release the timing restarts exactly as in scenario 1.
- With VGA_BORDER_EN and px_in=12'h000:
  - r/g/b=12'hFFF on row 0 (all 640 pixels), row 479, and columns 0/639 of every row;
  - 12'h000 elsewhere.

Source files
------------

// File: rtl/vga_scan_if.sv
// ---------------------------------------------------------------------------
// vga_scan_if
// Bundles the scan-side bus between the VGA timing block and the per-pixel
// layer generators / VGA connector.
//   px_in    : composited colour {r,g,b} from the layer generators
//   col_addr : current visible column (0 outside the active region)
//   row_addr : current visible row (0 outside the active region)
//   fresh    : high during vertical blanking (per-frame update strobe)
//   hs, vs   : active-low syncs, aligned with de and r/g/b
//   de       : aligned display-enable
//   r, g, b  : aligned 4-bit colour components
// Modports:
//   master : the timing block (drives addresses, sync and colour)
//   slave  : the layer side (drives px_in, observes everything else)
// ---------------------------------------------------------------------------
interface vga_scan_if;
    logic [11:0] px_in;
    logic [9:0]  col_addr;
    logic [8:0]  row_addr;
    logic        fresh;
    logic        hs;
    logic        vs;
    logic        de;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;

    modport master (
        input  px_in,
        output col_addr, row_addr, fresh, hs, vs, de, r, g, b
    );

    modport slave (
        output px_in,
        input  col_addr, row_addr, fresh, hs, vs, de, r, g, b
    );
endinterface

// File: rtl/vga_scan.sv
// ---------------------------------------------------------------------------
// vga_scan
// 640x480@60 Hz VGA scan generator. Counts pixels/lines, presents the visible
// coordinate to the layer generators, takes their colour back PX_LAT clocks
// later and re-aligns hsync/vsync/de with that colour. Also produces `fresh`,
// high during vertical blanking, for per-frame motion updates.
//
// Ports:
//   clk   : 25 MHz pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : vga_scan_if.master (px_in in; col_addr, row_addr, fresh,
//           hs, vs, de, r, g, b out)
//
// Optional build macro:
//   VGA_BORDER_EN : force r/g/b to 4'hF on the outermost visible rows and
//                   columns; interior pixels pass px_in unchanged.
// ---------------------------------------------------------------------------
module vga_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PX_LAT   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_scan_if.master   bus
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]        h_cnt_r;
    logic [9:0]        v_cnt_r;
    logic [9:0]        h_next_s;
    logic [9:0]        v_next_s;
    logic [9:0]        col_addr_r;
    logic [8:0]        row_addr_r;
    logic              fresh_r;

    logic              hs_raw_s;
    logic              vs_raw_s;
    logic              de_raw_s;
    logic [PX_LAT-1:0] hs_pipe_r;
    logic [PX_LAT-1:0] vs_pipe_r;
    logic [PX_LAT-1:0] de_pipe_r;

    logic              hs_r;
    logic              vs_r;
    logic              de_r;
    logic [11:0]       rgb_r;

`ifdef VGA_BORDER_EN
    logic              border_raw_s;
    logic [PX_LAT-1:0] border_pipe_r;
`endif

    // Next counter values: h wraps at end of line and carries into v.
    always_comb begin
        h_next_s = h_cnt_r;
        v_next_s = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_next_s = 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_next_s = h_cnt_r + 10'd1;
        end
    end

    // Raw timing decoded from the current counter values.
    always_comb begin
        de_raw_s = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
        hs_raw_s = !((h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END));
        vs_raw_s = !((v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END));
    end

`ifdef VGA_BORDER_EN
    // Border flag travels with de so it lines up with the returned colour.
    always_comb begin
        border_raw_s = de_raw_s &&
                       ((h_cnt_r == 10'd0) || (h_cnt_r == H_ACT - 10'd1) ||
                        (v_cnt_r == 10'd0) || (v_cnt_r == V_ACT - 10'd1));
    end
`endif

    // Pixel/line counters plus addresses registered from the next counter
    // values, so the addresses carry no extra latency over the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r    <= 10'd0;
            v_cnt_r    <= 10'd0;
            col_addr_r <= 10'd0;
            row_addr_r <= 9'd0;
        end else begin
            h_cnt_r    <= h_next_s;
            v_cnt_r    <= v_next_s;
            col_addr_r <= (h_next_s < H_ACT) ? h_next_s : 10'd0;
            row_addr_r <= (v_next_s < V_ACT) ? v_next_s[8:0] : 9'd0;
        end
    end

    // Delay pipe matching the layer generators' colour latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe_r <= {PX_LAT{1'b1}};
            vs_pipe_r <= {PX_LAT{1'b1}};
            de_pipe_r <= {PX_LAT{1'b0}};
        end else begin
            hs_pipe_r[0] <= hs_raw_s;
            vs_pipe_r[0] <= vs_raw_s;
            de_pipe_r[0] <= de_raw_s;
            for (int i = 1; i < PX_LAT; i++) begin
                hs_pipe_r[i] <= hs_pipe_r[i-1];
                vs_pipe_r[i] <= vs_pipe_r[i-1];
                de_pipe_r[i] <= de_pipe_r[i-1];
            end
        end
    end

`ifdef VGA_BORDER_EN
    // Border flag pipe, same depth as the sync/de pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            border_pipe_r <= {PX_LAT{1'b0}};
        end else begin
            border_pipe_r[0] <= border_raw_s;
            for (int i = 1; i < PX_LAT; i++) begin
                border_pipe_r[i] <= border_pipe_r[i-1];
            end
        end
    end
`endif

    // Output registers: aligned sync/de, gated colour and blanking strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r    <= 1'b1;
            vs_r    <= 1'b1;
            de_r    <= 1'b0;
            rgb_r   <= 12'h000;
            fresh_r <= 1'b0;
        end else begin
            hs_r    <= hs_pipe_r[PX_LAT-1];
            vs_r    <= vs_pipe_r[PX_LAT-1];
            de_r    <= de_pipe_r[PX_LAT-1];
            fresh_r <= (v_cnt_r >= V_ACT);
            if (de_pipe_r[PX_LAT-1]) begin
`ifdef VGA_BORDER_EN
                if (border_pipe_r[PX_LAT-1]) begin
                    rgb_r <= 12'hFFF;
                end else begin
                    rgb_r <= bus.px_in;
                end
`else
                rgb_r <= bus.px_in;
`endif
            end else begin
                rgb_r <= 12'h000;
            end
        end
    end

    assign bus.col_addr = col_addr_r;
    assign bus.row_addr = row_addr_r;
    assign bus.fresh    = fresh_r;
    assign bus.hs       = hs_r;
    assign bus.vs       = vs_r;
    assign bus.de       = de_r;
    assign bus.r        = rgb_r[11:8];
    assign bus.g        = rgb_r[7:4];
    assign bus.b        = rgb_r[3:0];

endmodule

// File: tb/tb_vga_scan.sv
// ---------------------------------------------------------------------------
// tb_vga_scan
// Self-checking bench for vga_scan using a reduced timing geometry so several
// whole frames fit in a short run. Expected outputs are computed from the
// number of clocks since reset release with plain arithmetic. The bench
// plays the layer generators: px_in returns a salted function of the address
// presented PX_LAT clocks earlier. Honours VGA_BORDER_EN in its model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_scan;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HSY = 6;
    localparam int HBP = 4;
    localparam int VA  = 10;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 3;
    localparam int L   = 2;
    localparam int HT  = HA + HFP + HSY + HBP;   // 30
    localparam int VT  = VA + VFP + VSY + VBP;   // 17
    localparam int FRAME = HT * VT;              // 510

    logic clk;
    logic rst_n;
    logic [11:0] salt;
    int   k;
    int   n_cmp;
    int   n_bad;
    logic [18:0] addr_q[$];

    vga_scan_if bus ();

    vga_scan #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .PX_LAT(L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Colour the bench's layer generator returns for pixel (x,y).
    function automatic logic [11:0] gen_px(int x, int y);
        logic [3:0] xa;
        logic [3:0] ya;
        xa = 4'(x);
        ya = 4'(y);
        return {xa, ya, 4'h5} ^ salt;
    endfunction

    // Colour that must appear on r/g/b for visible pixel (x,y).
    function automatic logic [11:0] exp_px(int x, int y);
`ifdef VGA_BORDER_EN
        if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 12'hFFF;
`endif
        return gen_px(x, y);
    endfunction

    // Expected {col,row,fresh,hs,vs,de,rgb} after k clocks since release.
    function automatic logic [34:0] exp_vec(int kk);
        int h, v, j, hj, vj;
        logic [9:0] col;
        logic [8:0] row;
        logic fr, hs, vs, de;
        logic [11:0] rgb;
        h   = kk % HT;
        v   = (kk / HT) % VT;
        col = (h < HA) ? 10'(h) : 10'd0;
        row = (v < VA) ? 9'(v) : 9'd0;
        fr  = (kk >= 1) && ((((kk - 1) / HT) % VT) >= VA);
        hs  = 1'b1; vs = 1'b1; de = 1'b0; rgb = 12'h000;
        if (kk >= L + 1) begin
            j  = kk - L - 1;
            hj = j % HT;
            vj = (j / HT) % VT;
            de = (hj < HA) && (vj < VA);
            hs = !((hj >= HA + HFP) && (hj < HA + HFP + HSY));
            vs = !((vj >= VA + VFP) && (vj < VA + VFP + VSY));
            if (de) rgb = exp_px(hj, vj);
        end
        return {col, row, fr, hs, vs, de, rgb};
    endfunction

    task automatic check(string name, int kk, logic [34:0] act, logic [34:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s k=%0d got %h required %h", name, kk, act, req);
        end
    endtask

    function automatic logic [34:0] dut_vec();
        return {bus.col_addr, bus.row_addr, bus.fresh, bus.hs, bus.vs, bus.de,
                bus.r, bus.g, bus.b};
    endfunction

    // Compare process plus layer-generator model, 1 ns after each edge.
    initial begin
        k = 0;
        bus.px_in = 12'h000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) k = 0;
            else        k = k + 1;
            check("cycle", k, dut_vec(), exp_vec(k));
            addr_q.push_back({bus.col_addr, bus.row_addr});
            if (addr_q.size() > L + 1) void'(addr_q.pop_front());
            if (addr_q.size() == L + 1)
                bus.px_in = gen_px(int'(addr_q[0][18:9]), int'(addr_q[0][8:0]));
            else
                bus.px_in = 12'h000;
        end
    end

    // Stimulus / run control.
    initial begin
        logic [34:0] e;
        int gap;
        n_cmp = 0;
        n_bad = 0;
        salt  = 12'($urandom_range(0, 4095));
        rst_n = 1'b0;

        // Hand-computed anchors for the reduced geometry (HT=30, frame=510).
        e = exp_vec(2);   check("pin_de_before", 2,   {34'd0, e[12]}, 35'd0);
        e = exp_vec(3);   check("pin_de_first",  3,   {34'd0, e[12]}, 35'd1);
        e = exp_vec(3);   check("pin_rgb_first", 3,   {23'd0, e[11:0]}, {23'd0, 12'h005 ^ salt});
        e = exp_vec(22);  check("pin_hs_before", 22,  {34'd0, e[14]}, 35'd1);
        e = exp_vec(23);  check("pin_hs_fall",   23,  {34'd0, e[14]}, 35'd0);
        e = exp_vec(29);  check("pin_hs_rise",   29,  {34'd0, e[14]}, 35'd1);
        e = exp_vec(20);  check("pin_col_blank", 20,  {25'd0, e[34:25]}, 35'd0);
        e = exp_vec(300); check("pin_fresh_lo",  300, {34'd0, e[15]}, 35'd0);
        e = exp_vec(301); check("pin_fresh_hi",  301, {34'd0, e[15]}, 35'd1);
        e = exp_vec(511); check("pin_fresh_end", 511, {34'd0, e[15]}, 35'd0);
        e = exp_vec(363); check("pin_vs_fall",   363, {34'd0, e[13]}, 35'd0);
        e = exp_vec(423); check("pin_vs_rise",   423, {34'd0, e[13]}, 35'd1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * FRAME + 20) @(posedge clk);

        // Mid-frame reset at a random point; outputs must clear at once.
        gap = $urandom_range(0, FRAME - 1);
        repeat (gap) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, dut_vec(), {35'd0} | (35'd1 << 14) | (35'd1 << 13));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME + 10) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
